// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reset_seq_pkg
// Brief   : Shared types and constants for the reset sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    localparam int CNT_W = 16;

    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 8;
    localparam int LOCK_FILTER_MIN = 1;
    localparam int LOCK_FILTER_MAX = 65535;
    localparam int HOLD_CYCLES_MIN = 1;
    localparam int HOLD_CYCLES_MAX = 65535;
    localparam int STAGGER_MIN     = 1;
    localparam int STAGGER_MAX     = 4095;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchroniser bank with asynchronous active-low reset.
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer
// Brief   : Qualifies PLL lock, holds resets, then releases channels staggered.
// Revision: 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int LOCK_FILTER = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4
) (
    input  logic                clk_osc_bufg,
    input  logic                reset_osc_n,
    input  logic                i_pll_lock,
    input  logic                i_reset_req,
    input  logic                i_stream_enable,
    output logic [CHANNELS-1:0] o_reset_n,
    output logic                o_reset_done,
    output logic                o_stream_enable
);

    import reset_seq_pkg::*;

    localparam logic [CNT_W-1:0] c_FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REL_LAST    = CNT_W'((CHANNELS - 1) * STAGGER);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        LOCK_FILTER < LOCK_FILTER_MIN || LOCK_FILTER > LOCK_FILTER_MAX ||
        HOLD_CYCLES < HOLD_CYCLES_MIN || HOLD_CYCLES > HOLD_CYCLES_MAX ||
        STAGGER < STAGGER_MIN || STAGGER > STAGGER_MAX) begin : g_bad_params
        $error("reset_sequencer: parameter out of range");
    end

    logic [2:0]          w_sync;
    logic                w_lock_s;
    logic                w_req_s;
    logic                w_sen_s;
    logic                w_req_rise;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_req_d;
    logic [CHANNELS-1:0] r_rst_n;
    logic [CHANNELS-1:0] w_rst_n_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_sen;

    sync_2ff #(
        .WIDTH (3)
    ) u_sync (
        .clk   (clk_osc_bufg),
        .rst_n (reset_osc_n),
        .i_d   ({i_stream_enable, i_reset_req, i_pll_lock}),
        .o_q   (w_sync)
    );

    assign w_lock_s   = w_sync[0];
    assign w_req_s    = w_sync[1];
    assign w_sen_s    = w_sync[2];
    assign w_req_rise = w_req_s & ~r_req_d;

    // Lock loss is tested before the request edge in every state so it wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rst_n_nxt = r_rst_n;
        case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt   = '0;
                w_rst_n_nxt = '0;
                if (w_lock_s) w_state_nxt = FILTER;
            end
            FILTER: begin
                w_rst_n_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (w_req_rise || r_cnt == c_FILTER_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                w_rst_n_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (w_req_rise) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_rst_n_nxt = '0;
                end else if (w_req_rise) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_rst_n_nxt = '0;
                end else begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (r_cnt == CNT_W'(k * STAGGER)) w_rst_n_nxt[k] = 1'b1;
                    end
                    if (r_cnt == c_REL_LAST) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                w_cnt_nxt   = '0;
                w_rst_n_nxt = '1;
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_rst_n_nxt = '0;
                end else if (w_req_rise) begin
                    w_state_nxt = HOLD;
                    w_rst_n_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
                w_rst_n_nxt = '0;
            end
        endcase
    end

    assign w_done_nxt = (w_state_nxt == DONE);

    always_ff @(posedge clk_osc_bufg or negedge reset_osc_n) begin
        if (!reset_osc_n) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_req_d <= 1'b0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_sen   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req_d <= w_req_s;
            r_rst_n <= w_rst_n_nxt;
            r_done  <= w_done_nxt;
            r_sen   <= w_sen_s & w_done_nxt;
        end
    end

    assign o_reset_n       = r_rst_n;
    assign o_reset_done    = r_done;
    assign o_stream_enable = r_sen;

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter CHANNELS, default 4: number of downstream reset outputs, legal range 1..8.
REQ-002 Parameter LOCK_FILTER, default 8: consecutive synchronised-lock cycles required before sequencing starts, legal range 1..65535.
REQ-003 Parameter HOLD_CYCLES, default 16: cycles all resets stay asserted after lock is qualified, legal range 1..65535.
REQ-004 Parameter STAGGER, default 4: cycles between successive channel releases, legal range 1..4095.
REQ-005 Port clk_osc_bufg, input, 1 bit: single clock; all logic runs in this domain.
REQ-006 Port reset_osc_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port i_pll_lock, input, 1 bit: asynchronous PLL lock indication.
REQ-008 Port i_reset_req, input, 1 bit: asynchronous software reset request (level); the rising edge is significant.
REQ-009 Port i_stream_enable, input, 1 bit: asynchronous stream enable.
REQ-010 Port o_reset_n, output, CHANNELS bits: registered active-low per-channel reset; bit 0 is released first.
REQ-011 Port o_reset_done, output, 1 bit: registered; high only when all channels are released.
REQ-012 Port o_stream_enable, output, 1 bit: registered; synchronised i_stream_enable gated by o_reset_done.

Function
REQ-013 i_pll_lock, i_reset_req and i_stream_enable SHALL each pass a 2-flop synchroniser; the second-flop outputs are lock_s, req_s and sen_s.
REQ-014 The FSM SHALL have exactly the states WAIT_LOCK, FILTER, HOLD, RELEASE and DONE, plus one shared 16-bit counter cnt.
REQ-015 WAIT_LOCK: all o_reset_n = 0; cnt = 0; lock_s = 1 moves the FSM to FILTER with cnt = 0.
REQ-016 FILTER: at each edge with lock_s = 1, cnt == LOCK_FILTER-1 moves the FSM to HOLD with cnt = 0; otherwise cnt increments; lock_s = 0 moves the FSM to WAIT_LOCK.
REQ-017 HOLD: all o_reset_n = 0; cnt == HOLD_CYCLES-1 moves the FSM to RELEASE with cnt = 0; otherwise cnt increments.
REQ-018 RELEASE: at the edge where cnt == k*STAGGER, o_reset_n[k] SHALL be set to 1; at the edge releasing bit CHANNELS-1, the FSM SHALL enter DONE and o_reset_done SHALL be set to 1; otherwise cnt increments.
REQ-019 Once released, o_reset_n bits SHALL stay 1 until the FSM reenters WAIT_LOCK or HOLD.
REQ-020 DONE: o_reset_n = all ones; o_reset_done = 1; FSM holds.
REQ-021 Lock loss: lock_s = 0 in HOLD, RELEASE or DONE SHALL move the FSM to WAIT_LOCK; at that same edge all o_reset_n, o_reset_done and o_stream_enable SHALL be cleared.
REQ-022 Reset request: a req_s rising edge (req_s = 1 with previous value 0) in FILTER, HOLD, RELEASE or DONE SHALL move the FSM to HOLD with cnt = 0; all outputs SHALL be cleared at that edge.
REQ-023 A req_s rising edge in WAIT_LOCK SHALL be ignored.
REQ-024 Priority: lock loss SHALL override a simultaneous reset request.
REQ-025 A request arriving during HOLD SHALL restart the hold count from 0.
REQ-026 o_stream_enable SHALL be registered (sen_s AND next-state o_reset_done).
REQ-027 o_stream_enable SHALL fall at the same edge as o_reset_done.
REQ-028 CHANNELS = 1: RELEASE SHALL last exactly one cycle.
REQ-029 cnt SHALL never wrap, because every parameter bound is below 2^16; (CHANNELS-1)*STAGGER SHALL fit in 16 bits.

Reset
REQ-030 While reset_osc_n = 0: FSM = WAIT_LOCK; cnt, synchroniser flops and req_s history = 0; o_reset_n = 0; o_reset_done = 0; o_stream_enable = 0.
REQ-031 Reset SHALL assert asynchronously and release on the first rising clock edge after deassertion.
REQ-032 Assertion mid-sequence SHALL abandon the sequence with no partial release retained.

Structure
REQ-033 Package reset_seq_pkg SHALL hold the state enum type, CNT_W = 16, and the parameter range constants.
REQ-034 One sub-module, sync_2ff (parametrised width, async active-low reset), SHALL be instantiated once with width 3.

Verification (CHANNELS=4, LOCK_FILTER=8, HOLD_CYCLES=16, STAGGER=4; E0 = first edge sampling i_pll_lock=1 from WAIT_LOCK)
REQ-035 Power-up: lock held high -> FILTER after E2, HOLD after E10, RELEASE after E26; o_reset_n bits 0..3 rise after E27/E31/E35/E39; o_reset_done rises after E39.
REQ-036 Lock glitch: lock high 5 cycles then low in FILTER -> back to WAIT_LOCK, o_reset_n stays 0000, and a full LOCK_FILTER count restarts on the next lock.
REQ-037 Lock loss in DONE with i_stream_enable=1: lock low -> after 3 edges o_reset_n = 0000, o_reset_done = 0, o_stream_enable = 0, FSM in WAIT_LOCK.
REQ-038 i_reset_req pulse during RELEASE after bit 1 released -> all outputs cleared; re-release: bit 0 at 17 edges after HOLD entry, then every 4 edges.
REQ-039 Simultaneous lock loss and request edge -> FSM in WAIT_LOCK, not HOLD.
REQ-040 reset_osc_n low mid-RELEASE -> outputs 0 immediately (asynchronous); after release, the full sequence repeats per REQ-035.
